// File: rtl/sar_adc_pkg.sv
// sar_adc_pkg: shared states and sizing for the SAR ADC controller
package sar_adc_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, DECIDE} state_t;
  localparam int DEF_WIDTH = 10;
  localparam int DEF_SETTLE_CYC = 2;
  localparam int IDX_W = $clog2(DEF_WIDTH);
  localparam int CNT_W = 4;
endpackage

// File: rtl/sar_settle_timer.sv
// sar_settle_timer: loadable down-counter that flags the end of a DAC settle window
module sar_settle_timer
  import sar_adc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign expired = cnt == '0;
endmodule

// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: binary-search SAR controller driving a DAC and sampling a comparator
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp,
  output logic [WIDTH-1:0] d,
  output logic             en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data,
  output logic             valid
);
  localparam int IW = $clog2(WIDTH);
  state_t state, state_n;
  logic [WIDTH-1:0] d_n, data_n, code;
  logic [IW-1:0] idx, idx_n;
  logic valid_n, done_n, busy_n, load, expired;
  sar_settle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (CNT_W'(SETTLE_CYC - 1)),
    .expired  (expired)
  );
  always_comb begin
    state_n = state;
    d_n = d;
    idx_n = idx;
    data_n = data;
    valid_n = valid;
    done_n = 1'b0;
    busy_n = busy;
    load = 1'b0;
    code = d;
    code[idx] = cmp;
    case (state)
      IDLE: begin
        d_n = '0;
        if (start) begin
          state_n = SETTLE;
          d_n = WIDTH'(1) << (WIDTH - 1);
          busy_n = 1'b1;
          valid_n = 1'b0;
          load = 1'b1;
        end
      end
      SETTLE: state_n = expired ? DECIDE : SETTLE;
      DECIDE: begin
        if (idx != '0) begin
          d_n = code | (WIDTH'(1) << (idx - 1'b1));
          idx_n = idx - 1'b1;
          load = 1'b1;
          state_n = SETTLE;
        end else begin
          data_n = code;
          done_n = 1'b1;
          valid_n = 1'b1;
          busy_n = 1'b0;
          d_n = '0;
          idx_n = IW'(WIDTH - 1);
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      d <= '0;
      idx <= IW'(WIDTH - 1);
      data <= '0;
      valid <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      d <= d_n;
      idx <= idx_n;
      data <= data_n;
      valid <= valid_n;
      done <= done_n;
      busy <= busy_n;
    end
  assign en = busy;
endmodule
